bus_master_if: RTL and testbench

//  Initiator-side bus interface: turns a single-word core access into the shared-bus
//  req_/grnt_/as_/ready_ handshake. Sits between one master (CPU, DMA) and one m<n>_* port
//  of the bus fabric. FSM-sequenced, with a wait-state timeout and a registered result to the core.

---
 rtl/bus_master_if_pkg.sv | 29 ++
 rtl/bus_timeout_cnt.sv | 41 ++++
 rtl/bus_master_if.sv | 162 ++++++++++++++++
 tb/tb_bus_master_if.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface slice.
//  - bus-wide widths and the read/write and active-low enable encodings
//  - 2-bit FSM state encodings
//  - cnt_width(): width of a counter that must be able to hold 0..limit
package bus_master_if_pkg;

  localparam int ADDR_WIDTH = 30;
  localparam int DATA_WIDTH = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // A disabled (zero) limit still gets a 1-bit counter so the vector stays legal.
  function automatic int cnt_width(input int limit);
    if (limit < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(limit + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-state timeout counter.
//  clk, reset : clock and synchronous active-high reset
//  clear      : force the count to zero (wins over enable)
//  enable     : count one wait cycle; saturates at TIMEOUT, never wraps
//  expired    : count has reached TIMEOUT-1; held low when TIMEOUT==0
module bus_timeout_cnt
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_C = (TIMEOUT > 32'sd0) ? CNT_W'(TIMEOUT - 32'sd1)
                                                          : {CNT_W{1'b0}};
  localparam logic             USE_C  = (TIMEOUT > 32'sd0);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear has priority, increment stops at the saturation value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable && (cnt_r != SAT_C)) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = USE_C && (cnt_r == LAST_C);

endmodule

// File: rtl/bus_master_if.sv
// Initiator-side bus interface: converts one single-word core access into the
// active-low req_/grnt_/as_/ready_ shared-bus handshake.
//  core_req/core_rw/core_addr/core_wr_data : access request from the core
//  core_busy/core_done/core_err/core_rd_data : registered status/result to the core
//  bus_req_/bus_as_/bus_rw/bus_addr/bus_wr_data : registered drive to the fabric
//  bus_grnt_/bus_ready_/bus_rd_data : arbiter grant and muxed slave response
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int DATA_W  = DATA_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_rw,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_busy,
  output logic              core_done,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic              bus_ready_,
  input  logic [DATA_W-1:0] bus_rd_data
);

  logic [1:0]        state_r;
  logic              bus_req_r;
  logic              bus_as_r;
  logic              bus_rw_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wr_data_r;
  logic              core_busy_r;
  logic              core_done_r;
  logic              core_err_r;
  logic [DATA_W-1:0] core_rd_data_r;

  logic              ready_s;
  logic              tmo_clear_s;
  logic              tmo_enable_s;
  logic              tmo_expired_s;

  // ready_ only matters while the strobe phase or a wait state is active.
  assign ready_s      = (bus_ready_ == ENABLE_);
  // Leaving ACCESS without ready is the only way into WAIT, so clearing there
  // guarantees WAIT starts from zero.
  assign tmo_clear_s  = (state_r == ST_ACCESS);
  assign tmo_enable_s = (state_r == ST_WAIT) && !ready_s;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (tmo_expired_s)
  );

  // Handshake sequencer and all registered outputs; done/err are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      bus_req_r      <= DISABLE_;
      bus_as_r       <= DISABLE_;
      bus_rw_r       <= READ;
      bus_addr_r     <= {ADDR_W{1'b0}};
      bus_wr_data_r  <= {DATA_W{1'b0}};
      core_busy_r    <= 1'b0;
      core_done_r    <= 1'b0;
      core_err_r     <= 1'b0;
      core_rd_data_r <= {DATA_W{1'b0}};
    end else begin
      core_done_r <= 1'b0;
      core_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (core_req) begin
            bus_rw_r      <= core_rw;
            bus_addr_r    <= core_addr;
            bus_wr_data_r <= core_wr_data;
            bus_req_r     <= ENABLE_;
            core_busy_r   <= 1'b1;
            state_r       <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // No limit on how long the arbiter may withhold the grant.
          if (bus_grnt_ == ENABLE_) begin
            bus_as_r <= ENABLE_;
            state_r  <= ST_ACCESS;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_ACCESS: begin
          bus_as_r <= DISABLE_;
          if (ready_s) begin
            if (bus_rw_r == READ) begin
              core_rd_data_r <= bus_rd_data;
            end else begin
              core_rd_data_r <= core_rd_data_r;
            end
            core_done_r <= 1'b1;
            bus_req_r   <= DISABLE_;
            core_busy_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ready_s) begin
            if (bus_rw_r == READ) begin
              core_rd_data_r <= bus_rd_data;
            end else begin
              core_rd_data_r <= core_rd_data_r;
            end
            core_done_r <= 1'b1;
            bus_req_r   <= DISABLE_;
            core_busy_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (tmo_expired_s) begin
            core_err_r  <= 1'b1;
            bus_req_r   <= DISABLE_;
            core_busy_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          // Unreachable encoding: release the bus and fall back to IDLE quietly.
          bus_req_r   <= DISABLE_;
          bus_as_r    <= DISABLE_;
          core_busy_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req_     = bus_req_r;
  assign bus_as_      = bus_as_r;
  assign bus_rw       = bus_rw_r;
  assign bus_addr     = bus_addr_r;
  assign bus_wr_data  = bus_wr_data_r;
  assign core_busy    = core_busy_r;
  assign core_done    = core_done_r;
  assign core_err     = core_err_r;
  assign core_rd_data = core_rd_data_r;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed self-checking bench for bus_master_if (TIMEOUT = 8).
module tb_bus_master_if;

  logic        clk;
  logic        reset;
  logic        core_req;
  logic        core_rw;
  logic [29:0] core_addr;
  logic [31:0] core_wr_data;
  logic        core_busy;
  logic        core_done;
  logic        core_err;
  logic [31:0] core_rd_data;
  logic        bus_req_;
  logic        bus_grnt_;
  logic        bus_as_;
  logic        bus_rw;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_ready_;
  logic [31:0] bus_rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  bus_master_if #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_req     (core_req),
    .core_rw      (core_rw),
    .core_addr    (core_addr),
    .core_wr_data (core_wr_data),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .core_err     (core_err),
    .core_rd_data (core_rd_data),
    .bus_req_     (bus_req_),
    .bus_grnt_    (bus_grnt_),
    .bus_as_      (bus_as_),
    .bus_rw       (bus_rw),
    .bus_addr     (bus_addr),
    .bus_wr_data  (bus_wr_data),
    .bus_ready_   (bus_ready_),
    .bus_rd_data  (bus_rd_data)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled half a period after the edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin : stim
    int first_err;
    int n_err;
    int n_done;
    int n_done2;
    logic [5:0] req_hist;

    reset        = 1'b1;
    core_req     = 1'b0;
    core_rw      = 1'b1;
    core_addr    = 30'h0;
    core_wr_data = 32'h0;
    bus_grnt_    = 1'b1;
    bus_ready_   = 1'b1;
    bus_rd_data  = 32'h0;
    cyc();
    cyc();

    // Reset state
    chk("rst_req_", {63'd0, bus_req_}, 64'd1);
    chk("rst_as_", {63'd0, bus_as_}, 64'd1);
    chk("rst_rw", {63'd0, bus_rw}, 64'd1);
    chk("rst_addr", {34'd0, bus_addr}, 64'd0);
    chk("rst_wdata", {32'd0, bus_wr_data}, 64'd0);
    chk("rst_busy_done_err", {61'd0, core_busy, core_done, core_err}, 64'd0);
    chk("rst_rdata", {32'd0, core_rd_data}, 64'd0);
    reset = 1'b0;

    // 1: read, grant one cycle later, zero-wait slave
    core_req  = 1'b1;
    core_rw   = 1'b1;
    core_addr = 30'h2A;
    cyc();
    chk("t1_req_low", {63'd0, bus_req_}, 64'd0);
    chk("t1_busy", {63'd0, core_busy}, 64'd1);
    chk("t1_as_high", {63'd0, bus_as_}, 64'd1);
    chk("t1_addr", {34'd0, bus_addr}, 64'h2A);
    chk("t1_rw", {63'd0, bus_rw}, 64'd1);
    core_req  = 1'b0;
    bus_grnt_ = 1'b0;
    cyc();
    chk("t1_as_low", {63'd0, bus_as_}, 64'd0);
    chk("t1_no_done_yet", {63'd0, core_done}, 64'd0);
    bus_ready_  = 1'b0;
    bus_rd_data = 32'hDEAD_BEEF;
    cyc();
    chk("t1_done", {63'd0, core_done}, 64'd1);
    chk("t1_rdata", {32'd0, core_rd_data}, 64'hDEAD_BEEF);
    chk("t1_req_high", {63'd0, bus_req_}, 64'd1);
    chk("t1_busy_clr", {63'd0, core_busy}, 64'd0);
    chk("t1_as_high_after", {63'd0, bus_as_}, 64'd1);
    bus_ready_ = 1'b1;
    bus_grnt_  = 1'b1;
    cyc();
    chk("t1_done_pulse", {63'd0, core_done}, 64'd0);

    // 2: write with four wait states; core-side inputs change after acceptance
    core_req     = 1'b1;
    core_rw      = 1'b0;
    core_addr    = 30'h100;
    core_wr_data = 32'h1234_5678;
    bus_grnt_    = 1'b0;
    bus_rd_data  = 32'h5555_AAAA;
    cyc();
    chk("t2_req_low", {63'd0, bus_req_}, 64'd0);
    chk("t2_rw", {63'd0, bus_rw}, 64'd0);
    core_req     = 1'b0;
    core_addr    = 30'h3FF;
    core_wr_data = 32'hFFFF_FFFF;
    cyc();
    chk("t2_as_low", {63'd0, bus_as_}, 64'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait_as", {63'd0, bus_as_}, 64'd1);
      chk("t2_wait_addr", {34'd0, bus_addr}, 64'h100);
      chk("t2_wait_wdata", {32'd0, bus_wr_data}, 64'h1234_5678);
      chk("t2_wait_req_done", {62'd0, bus_req_, core_done}, 64'd0);
      cyc();
    end
    bus_ready_ = 1'b0;
    cyc();
    chk("t2_done", {63'd0, core_done}, 64'd1);
    chk("t2_rdata_kept", {32'd0, core_rd_data}, 64'hDEAD_BEEF);
    chk("t2_req_high", {63'd0, bus_req_}, 64'd1);
    bus_ready_ = 1'b1;
    bus_grnt_  = 1'b1;
    cyc();
    chk("t2_done_once", {63'd0, core_done}, 64'd0);

    // 3: grant withheld for 20 cycles
    core_req  = 1'b1;
    core_rw   = 1'b1;
    core_addr = 30'h3;
    cyc();
    core_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_req_as_busy", {61'd0, bus_req_, bus_as_, core_busy}, 64'b011);
      cyc();
    end
    bus_grnt_ = 1'b0;
    cyc();
    chk("t3_as_low", {63'd0, bus_as_}, 64'd0);
    bus_ready_  = 1'b0;
    bus_rd_data = 32'hCAFE_0001;
    cyc();
    chk("t3_done", {63'd0, core_done}, 64'd1);
    chk("t3_rdata", {32'd0, core_rd_data}, 64'hCAFE_0001);
    bus_ready_ = 1'b1;
    bus_grnt_  = 1'b1;
    cyc();

    // 4: slave never answers -> timeout after 8 wait cycles
    core_req    = 1'b1;
    core_rw     = 1'b1;
    core_addr   = 30'h5;
    bus_grnt_   = 1'b0;
    bus_rd_data = 32'h7777_7777;
    cyc();
    core_req = 1'b0;
    cyc();
    cyc();
    bus_grnt_ = 1'b1;
    first_err = -1;
    n_err     = 0;
    n_done    = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (core_done) n_done++;
      if (core_err) begin
        n_err++;
        if (first_err < 0) begin
          first_err = i;
          chk("t4_req_high", {63'd0, bus_req_}, 64'd1);
          chk("t4_busy_clr", {63'd0, core_busy}, 64'd0);
          chk("t4_rdata_kept", {32'd0, core_rd_data}, 64'hCAFE_0001);
        end
      end
    end
    chk("t4_err_count", 64'(n_err), 64'd1);
    chk("t4_err_cycle", 64'(first_err), 64'd7);
    chk("t4_no_done", 64'(n_done), 64'd0);
    // next request accepted; ready_ low early must be ignored until ACCESS
    core_req    = 1'b1;
    core_rw     = 1'b1;
    bus_grnt_   = 1'b0;
    bus_ready_  = 1'b0;
    bus_rd_data = 32'h0BAD_F00D;
    cyc();
    chk("t4_next_busy_req", {62'd0, core_busy, bus_req_}, 64'b10);
    chk("t4_next_no_done", {63'd0, core_done}, 64'd0);
    core_req = 1'b0;
    cyc();
    chk("t4_next_as_low", {63'd0, bus_as_}, 64'd0);
    chk("t4_next_no_done2", {63'd0, core_done}, 64'd0);
    cyc();
    chk("t4_next_done", {63'd0, core_done}, 64'd1);
    chk("t4_next_rdata", {32'd0, core_rd_data}, 64'h0BAD_F00D);
    bus_ready_ = 1'b1;
    bus_grnt_  = 1'b1;
    cyc();

    // 5: core_req while busy is ignored; reset in WAIT
    core_req     = 1'b1;
    core_rw      = 1'b0;
    core_addr    = 30'h7;
    core_wr_data = 32'h55;
    bus_grnt_    = 1'b0;
    cyc();
    core_req = 1'b0;
    cyc();
    cyc();
    core_req  = 1'b1;
    core_rw   = 1'b1;
    core_addr = 30'h9;
    cyc();
    chk("t5_busy_ignore_addr", {34'd0, bus_addr}, 64'h7);
    chk("t5_busy_ignore_rw", {63'd0, bus_rw}, 64'd0);
    chk("t5_in_wait", {62'd0, core_busy, bus_as_}, 64'b11);
    core_req = 1'b0;
    reset    = 1'b1;
    cyc();
    chk("t5_rst_req_as_rw", {61'd0, bus_req_, bus_as_, bus_rw}, 64'b111);
    chk("t5_rst_addr", {34'd0, bus_addr}, 64'd0);
    chk("t5_rst_wdata", {32'd0, bus_wr_data}, 64'd0);
    chk("t5_rst_busy_done_err", {61'd0, core_busy, core_done, core_err}, 64'd0);
    chk("t5_rst_rdata", {32'd0, core_rd_data}, 64'd0);
    reset = 1'b0;
    cyc();
    chk("t5_after_rst", {61'd0, core_busy, core_done, core_err}, 64'd0);
    bus_grnt_ = 1'b1;

    // 6: back-to-back requests with core_req held high
    core_req    = 1'b1;
    core_rw     = 1'b1;
    core_addr   = 30'h11;
    bus_grnt_   = 1'b0;
    bus_ready_  = 1'b0;
    bus_rd_data = 32'h1111_1111;
    req_hist    = 6'd0;
    n_done2     = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      req_hist[i] = bus_req_;
      if (core_done) begin
        n_done2++;
        if (i == 2) chk("t6_rdata1", {32'd0, core_rd_data}, 64'h1111_1111);
        else        chk("t6_rdata2", {32'd0, core_rd_data}, 64'h2222_2222);
      end
      if (i == 3) begin
        core_req    = 1'b0;
        bus_rd_data = 32'h2222_2222;
      end
    end
    chk("t6_done_count", 64'(n_done2), 64'd2);
    chk("t6_req_hist", {58'd0, req_hist}, 64'b100100);
    bus_ready_ = 1'b1;
    bus_grnt_  = 1'b1;
    cyc();
    chk("t6_idle", {62'd0, core_busy, bus_req_}, 64'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
